// File: rtl/alu_cmd_sequencer.sv
// Issue stage for an 8-bit registered ALU: buffers commands in a small FIFO,
// fires one en pulse per legal command and returns result/flags on a valid/ready port.
module alu_cmd_sequencer #(
  parameter int N       = 8,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic [2:0]   cmd_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic         alu_en,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carry,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_zero,
  output logic         rsp_illegal,
  output logic         busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(ALU_LAT + 1);
  localparam int FW = 2 * N + 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_reg, state_next;
  logic [FW-1:0]  fifo_mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  count_reg, count_next;
  logic [LW-1:0]  lat_cnt_reg, lat_cnt_next;
  logic [N-1:0]   alu_a_reg, alu_a_next, alu_b_reg, alu_b_next;
  logic [2:0]     alu_op_reg, alu_op_next;
  logic           alu_en_reg, alu_en_next;
  logic           rsp_valid_reg, rsp_valid_next;
  logic [N-1:0]   rsp_result_reg, rsp_result_next;
  logic           rsp_carry_reg, rsp_carry_next;
  logic           rsp_zero_reg, rsp_zero_next;
  logic           rsp_illegal_reg, rsp_illegal_next;

  logic           push, pop, load, fifo_empty, head_legal;
  logic [N-1:0]   head_a, head_b;
  logic [2:0]     head_op;

  assign fifo_empty = (count_reg == '0);
  assign cmd_ready  = (count_reg != CW'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = load;
  assign {head_a, head_b, head_op} = fifo_mem[rd_ptr_reg];
  // Opcodes 110 and 111 are undefined in the ALU and are never enabled.
  assign head_legal = !(head_op[2] && head_op[1]);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_a, cmd_b, cmd_op};
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    lat_cnt_next     = lat_cnt_reg;
    alu_a_next       = alu_a_reg;
    alu_b_next       = alu_b_reg;
    alu_op_next      = alu_op_reg;
    alu_en_next      = 1'b0;
    rsp_valid_next   = rsp_valid_reg;
    rsp_result_next  = rsp_result_reg;
    rsp_carry_next   = rsp_carry_reg;
    rsp_zero_next    = rsp_zero_reg;
    rsp_illegal_next = rsp_illegal_reg;
    load             = 1'b0;
    case (state_reg)
      IDLE: begin
        load = !fifo_empty;
      end
      ISSUE: begin
        // alu_en_reg is high here exactly when the issued opcode was legal.
        if (alu_en_reg) begin
          state_next   = WAIT;
          lat_cnt_next = LW'(ALU_LAT);
        end else begin
          state_next       = RESP;
          rsp_valid_next   = 1'b1;
          rsp_illegal_next = 1'b1;
          rsp_result_next  = '0;
          rsp_carry_next   = 1'b0;
          rsp_zero_next    = 1'b0;
        end
      end
      WAIT: begin
        lat_cnt_next = lat_cnt_reg - LW'(1);
        if (lat_cnt_reg == LW'(1)) begin
          state_next       = RESP;
          rsp_valid_next   = 1'b1;
          rsp_illegal_next = 1'b0;
          rsp_result_next  = alu_result;
          rsp_carry_next   = alu_carry;
          rsp_zero_next    = alu_zero;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
          load           = !fifo_empty;
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) begin
      state_next  = ISSUE;
      alu_a_next  = head_a;
      alu_b_next  = head_b;
      alu_op_next = head_op;
      alu_en_next = head_legal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      lat_cnt_reg     <= '0;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_op_reg      <= '0;
      alu_en_reg      <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_result_reg  <= '0;
      rsp_carry_reg   <= 1'b0;
      rsp_zero_reg    <= 1'b0;
      rsp_illegal_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      lat_cnt_reg     <= lat_cnt_next;
      alu_a_reg       <= alu_a_next;
      alu_b_reg       <= alu_b_next;
      alu_op_reg      <= alu_op_next;
      alu_en_reg      <= alu_en_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_result_reg  <= rsp_result_next;
      rsp_carry_reg   <= rsp_carry_next;
      rsp_zero_reg    <= rsp_zero_next;
      rsp_illegal_reg <= rsp_illegal_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  assign alu_a       = alu_a_reg;
  assign alu_b       = alu_b_reg;
  assign alu_op      = alu_op_reg;
  assign alu_en      = alu_en_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_result  = rsp_result_reg;
  assign rsp_carry   = rsp_carry_reg;
  assign rsp_zero    = rsp_zero_reg;
  assign rsp_illegal = rsp_illegal_reg;
  assign busy        = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: one instance with a 1-cycle stub ALU, one with a 3-cycle stub,
// and a queue-based scoreboard of expected responses in command order.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_op;

  logic       cmd_valid, cmd_ready, alu_en, alu_carry, alu_zero;
  logic       rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_illegal, busy;
  logic [7:0] alu_a, alu_b, alu_result, rsp_result;
  logic [2:0] alu_op;

  logic       cmd_valid3, cmd_ready3, alu_en3, alu_carry3, alu_zero3;
  logic       rsp_valid3, rsp_ready3, rsp_carry3, rsp_zero3, rsp_illegal3, busy3;
  logic [7:0] alu_a3, alu_b3, alu_result3, rsp_result3;
  logic [2:0] alu_op3;

  alu_cmd_sequencer #(.N(8), .DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  alu_cmd_sequencer #(.N(8), .DEPTH(4), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_en(alu_en3),
    .alu_result(alu_result3), .alu_carry(alu_carry3), .alu_zero(alu_zero3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_carry(rsp_carry3), .rsp_zero(rsp_zero3), .rsp_illegal(rsp_illegal3), .busy(busy3)
  );

  // Stub ALU behaviour: {zero, carry, result} of an 8-bit add.
  function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {s[7:0] == 8'd0, s[8], s[7:0]};
  endfunction

  logic [9:0] stub1_reg = '0;
  logic [9:0] stub3_reg [3];
  initial for (int i = 0; i < 3; i++) stub3_reg[i] = '0;
  always @(posedge clk) begin
    if (alu_en) stub1_reg <= alu_fn(alu_a, alu_b);
    if (alu_en3) stub3_reg[0] <= alu_fn(alu_a3, alu_b3);
    stub3_reg[1] <= stub3_reg[0];
    stub3_reg[2] <= stub3_reg[1];
  end
  assign {alu_zero, alu_carry, alu_result}    = stub1_reg;
  assign {alu_zero3, alu_carry3, alu_result3} = stub3_reg[2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  // Expected response {illegal, zero, carry, result}.
  function automatic logic [10:0] model_rsp(input cmd_t c);
    if (c.op >= 3'd6) return {1'b1, 10'd0};
    return {1'b0, alu_fn(c.a, c.b)};
  endfunction

  cmd_t sb_q[$];
  int   rise_q[$];
  int   rsp_count = 0;
  logic prev_valid = 1'b0, prev_en = 1'b0;

  // Monitor for the main instance; values at a falling edge are those the next rising edge sees.
  always @(negedge clk) begin
    cmd_t c;
    if (!rst_n) begin
      sb_q.delete();
      prev_valid = 1'b0;
      prev_en    = 1'b0;
    end else begin
      if (alu_en) begin
        check("en_single_cycle", 32'(prev_en), 32'd0);
        check("en_has_cmd", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          check("en_cmd", 32'({alu_a, alu_b, alu_op}), 32'(sb_q[0]));
          check("en_legal_op", 32'(sb_q[0].op < 3'd6), 32'd1);
        end
      end
      if (rsp_valid && !prev_valid) rise_q.push_back(cyc);
      if (rsp_valid && rsp_ready) begin
        check("rsp_has_cmd", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          c = sb_q.pop_front();
          check("rsp", 32'({rsp_illegal, rsp_zero, rsp_carry, rsp_result}), 32'(model_rsp(c)));
          rsp_count++;
          $display("rsp %0d: a=%0d b=%0d op=%0d -> result=%0d carry=%0b zero=%0b illegal=%0b",
                   rsp_count, c.a, c.b, c.op, rsp_result, rsp_carry, rsp_zero, rsp_illegal);
        end
      end
      if (cmd_valid && cmd_ready) sb_q.push_back({cmd_a, cmd_b, cmd_op});
      prev_valid = rsp_valid;
      prev_en    = alu_en;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the command.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      output int push_edge);
    logic ok;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    check("push_accepted", 32'(ok), 32'd1);
    push_edge = cyc + 1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int push_edge, output int lat, output int en_cnt);
    lat = -1;
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alu_en) en_cnt++;
      if (rsp_valid) begin
        lat = cyc - push_edge;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) break;
    end
    check({tag, "_queue_empty"}, 32'(sb_q.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_lat3(input logic [7:0] a, input logic [7:0] b, input logic [9:0] exp);
    int pe, en_edge, cap_edge;
    cmd_a = a; cmd_b = b; cmd_op = 3'd0; cmd_valid3 = 1'b1;
    @(negedge clk);
    check("lat3_ready", 32'(cmd_ready3), 32'd1);
    pe = cyc + 1;
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    en_edge = -100; cap_edge = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alu_en3) en_edge = cyc + 1;
      if (rsp_valid3) begin
        cap_edge = cyc;
        break;
      end
    end
    check("lat3_from_en", 32'(cap_edge - en_edge), 32'd3);
    check("lat3_from_push", 32'(cap_edge - pe), 32'd5);
    check("lat3_value", 32'({rsp_zero3, rsp_carry3, rsp_result3}), 32'(exp));
    $display("lat3 rsp: a=%0d b=%0d -> result=%0d carry=%0b zero=%0b",
             a, b, rsp_result3, rsp_carry3, rsp_zero3);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pe, pe0, lat, en_cnt, base;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_valid3 = 1'b0;
    rsp_ready = 1'b1; rsp_ready3 = 1'b1;
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu", 32'({alu_en, alu_a, alu_b, alu_op}), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_illegal, rsp_zero, rsp_carry, rsp_result}), 32'd0);
    @(posedge clk); #1;

    // Legal add that overflows to zero.
    push(8'd250, 8'd6, 3'd0, pe);
    wait_rsp(pe, lat, en_cnt);
    check("legal_latency", 32'(lat), 32'd3);
    check("legal_en_cycles", 32'(en_cnt), 32'd1);
    check("legal_rsp", 32'({rsp_illegal, rsp_zero, rsp_carry, rsp_result}), 32'h300);

    // Undefined opcode.
    push(8'd5, 8'd5, 3'd6, pe);
    wait_rsp(pe, lat, en_cnt);
    check("illegal_latency", 32'(lat), 32'd2);
    check("illegal_en_cycles", 32'(en_cnt), 32'd0);
    check("illegal_rsp", 32'({rsp_illegal, rsp_zero, rsp_carry, rsp_result}), 32'h400);
    repeat (2) @(posedge clk); #1;

    // Fill: one in flight plus DEPTH buffered while the consumer stalls.
    rsp_ready = 1'b0;
    base = rsp_count;
    for (int k = 0; k < 5; k++) push(8'(k * 40 + 7), 8'(k + 3), 3'(k % 6), pe);
    @(negedge clk);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    cmd_a = 8'd99; cmd_b = 8'd1; cmd_op = 3'd0; cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_refuse", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    drain("fill");
    check("fill_rsp_count", 32'(rsp_count - base), 32'd5);
    check("fill_cmd_ready", 32'(cmd_ready), 32'd1);

    // Back-to-back issue.
    rise_q.delete();
    base = rsp_count;
    push(8'd1, 8'd2, 3'd0, pe0);
    push(8'd3, 8'd4, 3'd0, pe);
    push(8'd10, 8'd20, 3'd0, pe);
    drain("b2b");
    check("b2b_rsp_count", 32'(rsp_count - base), 32'd3);
    check("b2b_rises", 32'(rise_q.size()), 32'd3);
    if (rise_q.size() == 3) begin
      check("b2b_first_lat", 32'(rise_q[0] - pe0), 32'd3);
      check("b2b_spacing_1", 32'(rise_q[1] - rise_q[0]), 32'd3);
      check("b2b_spacing_2", 32'(rise_q[2] - rise_q[1]), 32'd3);
    end

    // Reset while the first command waits on the ALU with two more buffered.
    push(8'd11, 8'd12, 3'd0, pe);
    push(8'd13, 8'd14, 3'd1, pe);
    push(8'd15, 8'd16, 3'd2, pe);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_outputs", 32'({alu_en, alu_a, alu_b, alu_op}), 32'd0);
    check("midrst_rsp", 32'({rsp_valid, rsp_illegal, rsp_zero, rsp_carry, rsp_result}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rise_q.delete();
    repeat (12) @(negedge clk);
    check("flush_no_rsp", 32'(rise_q.size()), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic against the scoreboard.
    base = rsp_count;
    for (int i = 0; i < 300; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_op    = 3'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain("rand");
    check("rand_progress", 32'(rsp_count - base > 20), 32'd1);

    // Longer ALU latency: capture must wait for the delayed result.
    run_lat3(8'd100, 8'd50, 10'h096);
    run_lat3(8'd200, 8'd60, 10'h104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the 8-bit registered ALU (ports A, B, op_code, clk, en, result_out, flag_carry, flag_zero). It buffers operand/opcode commands in a small FIFO and drives the ALU one command at a time with a single-cycle en pulse. After the ALU latency it captures result and flags, and presents them on a valid/ready response port. It decouples the command producer from ALU timing and screens undefined opcodes.

Parameters:
N, 8, operand/result width; matches the ALU.
DEPTH, 4, command FIFO entries; power of two, at least 2.
ALU_LAT, 1, clock edges from the ALU sampling en=1 to result_out/flags being valid; at least 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  FIFO can accept; equals not-full.
cmd_a  input  N  operand A.
cmd_b  input  N  operand B.
cmd_op  input  3  opcode.
alu_a  output  N  to ALU A.
alu_b  output  N  to ALU B.
alu_op  output  3  to ALU op_code.
alu_en  output  1  to ALU en; one-cycle pulse per legal command.
alu_result  input  N  from ALU result_out.
alu_carry  input  1  from ALU flag_carry.
alu_zero  input  1  from ALU flag_zero.
rsp_valid  output  1  response held until accepted.
rsp_ready  input  1  consumer accepts.
rsp_result  output  N  captured result.
rsp_carry  output  1  captured carry.
rsp_zero  output  1  captured zero.
rsp_illegal  output  1  command had undefined opcode 110 or 111.
busy  output  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (rst_n low, async): FIFO empty; FSM IDLE; all alu_* and rsp_* outputs 0; busy 0; cmd_ready 1 once the FIFO is empty. Assertion mid-operation discards the in-flight command and all buffered commands.
- FIFO: push on rising edge when cmd_valid && cmd_ready. Pop happens only on the IDLE->ISSUE edge. No push while full. Pointers wrap modulo DEPTH. cmd_ready is derived from registered occupancy, so a pop edge does not enable a same-edge push.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if the FIFO is non-empty, on the next edge load alu_a, alu_b and alu_op from the head, pop, and go to ISSUE. Set alu_en to 1 only if op is 000..101.
- ISSUE (exactly one cycle): alu_en deasserts on exit.
  - Legal op: go to WAIT with the wait counter set to ALU_LAT.
  - Illegal op: go to RESP, set rsp_illegal=1, and set rsp_result/rsp_carry/rsp_zero to 0. The ALU is not enabled.
- WAIT: decrement the counter each edge. On the edge where it reaches 0, capture alu_result, alu_carry and alu_zero into rsp_*, set rsp_illegal=0 and rsp_valid=1, and go to RESP.
- RESP: rsp_valid and rsp_* are held stable. On an edge with rsp_ready=1, drop rsp_valid.
  - If the FIFO is non-empty on that edge, load and pop the head directly, going to ISSUE (back-to-back issue).
  - Otherwise go to IDLE.
- alu_a, alu_b and alu_op hold the last issued values between commands.
- Latency from an empty, idle block, with rsp_ready held high:
  - Legal op: rsp_valid rises 2+ALU_LAT edges after the accepting push edge, i.e. 3 edges at ALU_LAT=1.
  - Illegal op: rsp_valid rises 2 edges after the accepting push edge.
- Throughput with the FIFO kept full and rsp_ready=1: one response every 2+ALU_LAT cycles.
- Commands complete strictly in FIFO order, one outstanding at a time.
- Pushes are accepted in any state, including while a response waits for rsp_ready.

Test Plan:
- Reset, then push A=250, B=6, op=000 into the real alu, with rsp_ready=1 -> alu_en is high for exactly one cycle; rsp_valid rises 3 edges after the push with rsp_result=0, rsp_carry=1, rsp_zero=1, rsp_illegal=0.
- Push op=110, A=5, B=5 -> alu_en stays 0 throughout; rsp_valid rises 2 edges after the push with rsp_illegal=1 and rsp_result=0.
- Hold rsp_ready=0 and push 5 commands, using a stub ALU returning alu_result = A+B mod 256. The first is issued, then the next 4 fill the FIFO -> cmd_ready=0 and a 6th push is refused. Release rsp_ready -> responses appear in order, cmd_ready returns to 1, and nothing is lost.
- Back-to-back with the stub: push (1,2), (3,4), (10,20) with rsp_ready=1 -> rsp_result is 3, 7, 30, spaced 3 cycles apart; busy drops after the last response is accepted.
- Assert rst_n low during WAIT, with 2 commands buffered -> all outputs go to 0 immediately and the FIFO is empty; after release, no response appears for the flushed commands.
- Set ALU_LAT=3 with a stub delaying its output 3 edges -> capture occurs 3 edges after alu_en is sampled; the correct value is captured and no earlier value is taken.
